if_unit: RTL and testbench
==========================

Name: if_unit

Overview:
- Instruction-fetch stage plus IF/ID pipeline register. Sits directly upstream of the decode/ID stage.
- Owns the PC and drives a synchronous-read instruction memory (1-cycle read latency).
- Registers the fetched word and presents pre-sliced instruction fields and the PC to decode.
- Handles stall (hold) and redirect (branch/call/ret target, squashes wrong-path fetches).

Parameters:
- RESET_VECTOR, 32'h00000000, PC loaded on reset.
- NOP_INSTR, 32'h00000000, instruction word held in IF/ID when empty or flushed.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hold fetch state and IF/ID contents.
- redirect  in  1  load new PC and flush in-flight fetches.
- redirect_pc  in  32  target word address.
- imem_addr  out  32  instruction memory read address, combinational.
- imem_rdata  in  32  instruction word for the address presented the previous cycle.
- inst_valid  out  1  IF/ID holds a real instruction.
- opcode  out  6  Inst[31:26].
- R_I_A_type_rd  out  5  Inst[25:21].
- R_type_rt  out  5  Inst[20:16].
- R_I_type_rs  out  5  Inst[15:11].
- R_type_shamt  out  5  Inst[10:6].
- I_type_imm  out  16  Inst[15:0].
- A_type_imm  out  21  Inst[20:0].
- J_type_imm  out  26  Inst[25:0].
- PC_out  out  32  address of the IF/ID instruction + 1 (word addressed).
- fetch_count  out  32  perf counter (see Optional Feature).
- stall_count  out  32  perf counter (see Optional Feature).

Behaviour:
- State:
  - fetch_pc: next address to issue.
  - rsp_pc, rsp_valid: the address whose data is on imem_rdata this cycle.
  - IF/ID: inst_q, pc_q, valid_q.
- Reset (rst low, async):
  - fetch_pc=RESET_VECTOR, rsp_valid=0, rsp_pc=0.
  - inst_q=NOP_INSTR, pc_q=0, inst_valid=0; all field outputs therefore reflect NOP_INSTR, PC_out=0.
- imem_addr is rsp_pc when (stall & rsp_valid & ~redirect), otherwise fetch_pc. The re-issue keeps the response alive across stalls.
- Field outputs are pure slices of inst_q. PC_out = pc_q + 1 (32-bit, wraps).
- Priority per edge is redirect > stall > normal.
- Redirect:
  - fetch_pc<=redirect_pc, rsp_valid<=0.
  - inst_q<=NOP_INSTR, inst_valid<=0, pc_q holds.
  - Redirect asserted with stall still flushes; the stall is ignored that cycle.
- Stall (no redirect): fetch_pc, rsp_pc, rsp_valid and the IF/ID registers all hold.
- Normal:
  - rsp_pc<=fetch_pc, rsp_valid<=1, fetch_pc<=fetch_pc+1 (wraps at 2^32).
  - If rsp_valid: inst_q<=imem_rdata, pc_q<=rsp_pc, inst_valid<=1.
  - Else: inst_q<=NOP_INSTR, inst_valid<=0.
- Latency:
  - First instruction after reset release reaches the outputs on the 2nd rising edge.
  - Redirect asserted in cycle N: target instruction is on the outputs in cycle N+3 (two bubbles).
- Steady state is one instruction per cycle with no bubbles.
- Reset asserted mid-stall or mid-redirect returns to the reset state immediately. No partial update survives.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined:
  - fetch_count increments on every edge where IF/ID loads a valid instruction.
  - stall_count increments on every edge with stall=1 and redirect=0.
  - Both are 32-bit, wrap, and clear on reset.
- Undefined: counters are not instantiated; fetch_count and stall_count are tied to 0.

Test Plan:
- Reset release, RESET_VECTOR=0, imem[i]=32'h1000_0000+i: imem_addr 0,1,2...; inst_valid rises 2nd edge; I_type_imm=16'h0000 with PC_out=1, then 16'h0001 with PC_out=2.
- Field slice, imem word 32'hFC21_0FFF: opcode=6'h3F, R_I_A_type_rd=1, R_type_rt=1, R_I_type_rs=1, R_type_shamt=5'h1F, I_type_imm=16'h0FFF.
- Stall 3 cycles mid-stream with instruction at address 5 in IF/ID: outputs frozen (PC_out=6) for 3 cycles; next edge loads address 6; no instruction lost or duplicated.
- Redirect to 32'h40 in cycle N while addresses 7 and 8 are in flight: inst_valid=0 in N+1 and N+2; N+3 shows instr(0x40), PC_out=0x41.
- Redirect and stall asserted together: flush takes effect, and imem_addr=redirect target next cycle. With IF_PERF_CNT_EN, 3 stall cycles plus 10 valid loads give stall_count=3, fetch_count=10; without the macro both read 0.
- Async reset pulse between clock edges while stalled: all outputs return to reset values immediately, and fetch resumes from RESET_VECTOR.

Source files
------------

// File: rtl/if_unit.sv
// Instruction-fetch stage with IF/ID pipeline register, driving a 1-cycle synchronous imem.
// Optional perf counters are built only when IF_PERF_CNT_EN is defined.
module if_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [5:0]  opcode,
  output logic [4:0]  R_I_A_type_rd,
  output logic [4:0]  R_type_rt,
  output logic [4:0]  R_I_type_rs,
  output logic [4:0]  R_type_shamt,
  output logic [15:0] I_type_imm,
  output logic [20:0] A_type_imm,
  output logic [25:0] J_type_imm,
  output logic [31:0] PC_out,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] inst_q, inst_d;
  // Holds the IF/ID address already incremented, so the reset value reads back as PC_out = 0.
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        advance;

  assign advance = ~redirect & ~stall;

  // Re-issuing the in-flight address during a stall keeps imem_rdata stable.
  assign imem_addr = (stall & rsp_valid_q & ~redirect) ? rsp_pc_q : fetch_pc_q;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_valid_d = rsp_valid_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    if (redirect) begin
      fetch_pc_d  = redirect_pc;
      rsp_valid_d = 1'b0;
      inst_d      = NOP_INSTR;
      valid_d     = 1'b0;
    end else if (!stall) begin
      rsp_pc_d    = fetch_pc_q;
      rsp_valid_d = 1'b1;
      fetch_pc_d  = fetch_pc_q + 32'd1;
      if (rsp_valid_q) begin
        inst_d  = imem_rdata;
        pc_d    = rsp_pc_q + 32'd1;
        valid_d = 1'b1;
      end else begin
        inst_d  = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q  <= RESET_VECTOR;
      rsp_pc_q    <= 32'd0;
      rsp_valid_q <= 1'b0;
      inst_q      <= NOP_INSTR;
      pc_q        <= 32'd0;
      valid_q     <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_valid_q <= rsp_valid_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
    end
  end

  assign inst_valid    = valid_q;
  assign opcode        = inst_q[31:26];
  assign R_I_A_type_rd = inst_q[25:21];
  assign R_type_rt     = inst_q[20:16];
  assign R_I_type_rs   = inst_q[15:11];
  assign R_type_shamt  = inst_q[10:6];
  assign I_type_imm    = inst_q[15:0];
  assign A_type_imm    = inst_q[20:0];
  assign J_type_imm    = inst_q[25:0];
  assign PC_out        = pc_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (advance && rsp_valid_q) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (stall && !redirect)     stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  logic unused_advance;
  assign unused_advance = advance;
  assign fetch_count    = 32'd0;
  assign stall_count    = 32'd0;
`endif

endmodule

// File: tb/tb_if_unit.sv
// Self-checking bench for if_unit: directed steps plus random stall/redirect traffic
// compared against a stream-level model (start address + count of advancing edges).
module tb_if_unit;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        inst_valid;
  logic [5:0]  opcode;
  logic [4:0]  R_I_A_type_rd, R_type_rt, R_I_type_rs, R_type_shamt;
  logic [15:0] I_type_imm;
  logic [20:0] A_type_imm;
  logic [25:0] J_type_imm;
  logic [31:0] PC_out, fetch_count, stall_count;

  int checks = 0;
  int errors = 0;

  // Model: the IF/ID stream since the last flush is base, base+1, ...; adv counts advancing edges.
  logic [31:0] m_base;
  int unsigned m_adv;
  logic [31:0] m_pc_out;
  logic [31:0] m_fetch_cnt, m_stall_cnt;

  if_unit #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .opcode(opcode), .R_I_A_type_rd(R_I_A_type_rd), .R_type_rt(R_type_rt),
    .R_I_type_rs(R_I_type_rs), .R_type_shamt(R_type_shamt), .I_type_imm(I_type_imm),
    .A_type_imm(A_type_imm), .J_type_imm(J_type_imm), .PC_out(PC_out),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (a == 32'h0000_0080) return 32'hFC21_0FFF;
    return 32'h1000_0000 + a;
  endfunction

  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_base      = RV;
    m_adv       = 0;
    m_pc_out    = 32'd0;
    m_fetch_cnt = 32'd0;
    m_stall_cnt = 32'd0;
  endtask

  task automatic model_edge();
    if (redirect) begin
      m_base = redirect_pc;
      m_adv  = 0;
    end else if (stall) begin
      m_stall_cnt++;
    end else begin
      if (m_adv >= 1) begin
        m_fetch_cnt++;
        m_pc_out = m_base + 32'(m_adv);
      end
      m_adv++;
    end
  endtask

  task automatic check_addr();
    logic [31:0] e;
    if (stall && !redirect && m_adv >= 1) e = m_base + 32'(m_adv) - 32'd1;
    else e = m_base + 32'(m_adv);
    chk("imem_addr", imem_addr, e);
  endtask

  task automatic check_outs();
    logic [31:0] e;
    logic        v;
    v = (m_adv >= 2);
    e = v ? mem_word(m_base + 32'(m_adv) - 32'd2) : NOP;
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, v});
    chk("opcode", {26'd0, opcode}, {26'd0, e[31:26]});
    chk("rd", {27'd0, R_I_A_type_rd}, {27'd0, e[25:21]});
    chk("rt", {27'd0, R_type_rt}, {27'd0, e[20:16]});
    chk("rs", {27'd0, R_I_type_rs}, {27'd0, e[15:11]});
    chk("shamt", {27'd0, R_type_shamt}, {27'd0, e[10:6]});
    chk("i_imm", {16'd0, I_type_imm}, {16'd0, e[15:0]});
    chk("a_imm", {11'd0, A_type_imm}, {11'd0, e[20:0]});
    chk("j_imm", {6'd0, J_type_imm}, {6'd0, e[25:0]});
    chk("pc_out", PC_out, m_pc_out);
`ifdef IF_PERF_CNT_EN
    chk("fetch_count", fetch_count, m_fetch_cnt);
    chk("stall_count", stall_count, m_stall_cnt);
`else
    chk("fetch_count", fetch_count, 32'd0);
    chk("stall_count", stall_count, 32'd0);
`endif
  endtask

  // Called at a negedge: apply inputs, check the combinational address, clock once, check state.
  task automatic cycle(logic s, logic r, logic [31:0] tgt);
    stall       = s;
    redirect    = r;
    redirect_pc = tgt;
    #1;
    check_addr();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs();
  endtask

  initial begin
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_addr();
    check_outs();
    rst = 1'b1;

    // Reset release: first instruction on the 2nd edge, then address 5 into IF/ID.
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 32'd0);
    chk("pc_out_at_addr5", PC_out, 32'd6);
    // Three stall cycles, then resume with address 6.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    chk("resume_after_stall", PC_out, 32'd7);

    // Redirect to 0x40: two bubbles, then instr(0x40).
    cycle(1'b0, 1'b1, 32'h40);
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    chk("redirect_target_pc", PC_out, 32'h41);
    cycle(1'b0, 1'b0, 32'd0);

    // Field-slice word at 0x80.
    cycle(1'b0, 1'b1, 32'h80);
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    chk("field_opcode", {26'd0, opcode}, 32'h3F);
    chk("field_shamt", {27'd0, R_type_shamt}, 32'h1F);

    // Redirect together with stall: the flush wins.
    cycle(1'b1, 1'b1, 32'h20);
    chk("redir_stall_addr", imem_addr, 32'h20);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0);

    // Random traffic, including targets that wrap the address space.
    for (int i = 0; i < 400; i++) begin
      logic        s, r;
      logic [31:0] t;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) == 0);
      t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : ($urandom & 32'hFF);
      cycle(s, r, t);
    end

    // Async reset pulse while stalled, between clock edges.
    cycle(1'b1, 1'b0, 32'd0);
    stall = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_addr();
    check_outs();
    @(posedge clk);
    @(negedge clk);
    check_outs();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'd0);
    chk("resume_from_reset_pc", PC_out, RV + 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
